// File: rtl/centroid_pair_collector_pkg.sv
// Shared constants and types for the centroid pair collector and the parallax depth stage.
package centroid_pair_collector_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int X_W         = 11;
  localparam int Y_W         = 10;

  localparam logic [1:0] ONE_PLAYER   = 2'b00;
  localparam logic [1:0] TWO_PLAYERS  = 2'b01;
  localparam logic [1:0] THREE_PLAYERS = 2'b10;
  localparam logic [1:0] FOUR_PLAYERS = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    EMIT    = 2'b10
  } collector_state_t;

  // Slots that must be written for a frame with the given player count code.
  function automatic logic [MAX_PLAYERS-1:0] active_mask(input logic [1:0] np);
    case (np)
      ONE_PLAYER:    return 4'b0001;
      TWO_PLAYERS:   return 4'b0011;
      THREE_PLAYERS: return 4'b0111;
      default:       return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/centroid_pair_collector_slot_bank.sv
// Per-camera centroid slot storage: x/y registers, written-slot mask and frame-done flag.
// Snapshot outputs show the bank contents with this cycle's beat already merged in.
module centroid_slot_bank
  import centroid_pair_collector_pkg::*;
#(
  parameter int N_SLOTS = MAX_PLAYERS,
  parameter int XW      = X_W,
  parameter int YW      = Y_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_wr_en,
  input  logic               i_wr_keep,
  input  logic               i_wr_last,
  input  logic [1:0]         i_wr_idx,
  input  logic [XW-1:0]      i_wr_x,
  input  logic [YW-1:0]      i_wr_y,
  output logic [XW-1:0]      o_snap_x [N_SLOTS],
  output logic [YW-1:0]      o_snap_y [N_SLOTS],
  output logic [N_SLOTS-1:0] o_snap_mask,
  output logic               o_done,
  output logic               o_done_next
);

  logic [XW-1:0]      r_x [N_SLOTS];
  logic [YW-1:0]      r_y [N_SLOTS];
  logic [N_SLOTS-1:0] r_mask;
  logic               r_done;
  logic               w_store;
  logic [N_SLOTS-1:0] w_hit;

  // Beats arriving after this camera closed its frame are dropped here.
  assign w_store     = i_wr_en & i_wr_keep & ~r_done;
  assign o_done      = r_done;
  assign o_done_next = r_done | (i_wr_en & i_wr_last);

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_hit[i] = w_store && (i_wr_idx == 2'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
      r_mask <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_mask <= '0;
      r_done <= 1'b0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_hit[i]) begin
          r_x[i]    <= i_wr_x;
          r_y[i]    <= i_wr_y;
          r_mask[i] <= 1'b1;
        end
      end
      if (i_wr_en && i_wr_last) r_done <= 1'b1;
    end
  end

  always_comb begin
    o_snap_mask = r_mask | w_hit;
    for (int i = 0; i < N_SLOTS; i++) begin
      o_snap_x[i] = w_hit[i] ? i_wr_x : r_x[i];
      o_snap_y[i] = w_hit[i] ? i_wr_y : r_y[i];
    end
  end

endmodule

// File: rtl/centroid_pair_collector.sv
// Collects per-camera centroid beats into one two-camera frame and emits it with a one-cycle pulse.
// Optional frame-abandon timer when COLLECTOR_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no beat accepted yet for this frame
// COLLECT | storing beats until both cameras have closed the frame
// EMIT    | snapshot presented, data_valid_out high, input stalled
module centroid_pair_collector #(
  parameter int MAX_PLAYERS    = 4,
  parameter int X_W            = 11,
  parameter int Y_W            = 10,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic [1:0]     num_players_in,
  input  logic           cen_valid_in,
  output logic           cen_ready_out,
  input  logic           cen_cam_in,
  input  logic [1:0]     cen_idx_in,
  input  logic [X_W-1:0] cen_x_in,
  input  logic [Y_W-1:0] cen_y_in,
  input  logic           cen_last_in,
  output logic           data_valid_out,
  output logic [1:0]     num_players_out,
  output logic [X_W-1:0] x_out_1 [MAX_PLAYERS],
  output logic [X_W-1:0] x_out_2 [MAX_PLAYERS],
  output logic [Y_W-1:0] y_out_1 [MAX_PLAYERS],
  output logic [Y_W-1:0] y_out_2 [MAX_PLAYERS],
  output logic           incomplete_out,
  output logic [7:0]     drop_count_out
);
  import centroid_pair_collector_pkg::*;

  collector_state_t       r_state, w_state_next;
  logic                   r_ready;
  logic [1:0]             r_num_players, w_np_eff;
  logic                   w_accept, w_keep, w_complete, w_timeout, w_bank_clr;
  logic                   w_wr1, w_wr2;
  logic                   w_done1, w_done2, w_done1_next, w_done2_next;
  logic [MAX_PLAYERS-1:0] w_mask1, w_mask2, w_act;
  logic [X_W-1:0]         w_snap_x1 [MAX_PLAYERS];
  logic [X_W-1:0]         w_snap_x2 [MAX_PLAYERS];
  logic [Y_W-1:0]         w_snap_y1 [MAX_PLAYERS];
  logic [Y_W-1:0]         w_snap_y2 [MAX_PLAYERS];

  assign w_accept   = cen_valid_in & r_ready;
  // The first beat of a frame is judged against the count it brings with it.
  assign w_np_eff   = (r_state == IDLE) ? num_players_in : r_num_players;
  assign w_keep     = (cen_idx_in <= w_np_eff);
  assign w_wr1      = w_accept & ~cen_cam_in;
  assign w_wr2      = w_accept & cen_cam_in;
  assign w_complete = w_accept & w_done1_next & w_done2_next;
  assign w_act      = active_mask(w_np_eff);

  centroid_slot_bank #(.N_SLOTS(MAX_PLAYERS), .XW(X_W), .YW(Y_W)) u_bank_cam1 (
    .i_clk       (clk_in),
    .i_rst_n     (rst_n_in),
    .i_clr       (w_bank_clr),
    .i_wr_en     (w_wr1),
    .i_wr_keep   (w_keep),
    .i_wr_last   (cen_last_in),
    .i_wr_idx    (cen_idx_in),
    .i_wr_x      (cen_x_in),
    .i_wr_y      (cen_y_in),
    .o_snap_x    (w_snap_x1),
    .o_snap_y    (w_snap_y1),
    .o_snap_mask (w_mask1),
    .o_done      (w_done1),
    .o_done_next (w_done1_next)
  );

  centroid_slot_bank #(.N_SLOTS(MAX_PLAYERS), .XW(X_W), .YW(Y_W)) u_bank_cam2 (
    .i_clk       (clk_in),
    .i_rst_n     (rst_n_in),
    .i_clr       (w_bank_clr),
    .i_wr_en     (w_wr2),
    .i_wr_keep   (w_keep),
    .i_wr_last   (cen_last_in),
    .i_wr_idx    (cen_idx_in),
    .i_wr_x      (cen_x_in),
    .i_wr_y      (cen_y_in),
    .o_snap_x    (w_snap_x2),
    .o_snap_y    (w_snap_y2),
    .o_snap_mask (w_mask2),
    .o_done      (w_done2),
    .o_done_next (w_done2_next)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != EMIT);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = COLLECT;
      COLLECT: begin
        if (w_complete)     w_state_next = EMIT;
        else if (w_timeout) w_state_next = IDLE;
      end
      EMIT:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    data_valid_out = (r_state == EMIT);
    cen_ready_out  = r_ready;
    w_bank_clr     = (r_state == EMIT) | w_timeout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_num_players <= '0;
    end else if (r_state == IDLE && w_accept) begin
      r_num_players <= num_players_in;
    end
  end

  // Unwritten slots keep whatever the previous frame left on the outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        x_out_1[i] <= '0;
        y_out_1[i] <= '0;
        x_out_2[i] <= '0;
        y_out_2[i] <= '0;
      end
      num_players_out <= '0;
      incomplete_out  <= 1'b0;
    end else if (w_complete) begin
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        if (w_mask1[i]) begin
          x_out_1[i] <= w_snap_x1[i];
          y_out_1[i] <= w_snap_y1[i];
        end
        if (w_mask2[i]) begin
          x_out_2[i] <= w_snap_x2[i];
          y_out_2[i] <= w_snap_y2[i];
        end
      end
      num_players_out <= w_np_eff;
      incomplete_out  <= ((w_mask1 & w_act) != w_act) | ((w_mask2 & w_act) != w_act);
    end
  end

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [7:0]       r_drop_cnt;
  logic             w_one_done;

  assign w_one_done = (r_state == COLLECT) & (w_done1 ^ w_done2);
  // A completing beat on the terminal count still emits the frame.
  assign w_timeout  = w_one_done & (r_tmo_cnt == '0) & ~w_complete;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tmo_cnt  <= TMO_W'(TIMEOUT_CYCLES - 1);
      r_drop_cnt <= '0;
    end else begin
      if (!w_one_done || w_timeout) r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      else                          r_tmo_cnt <= r_tmo_cnt - 1'b1;
      if (w_timeout && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count_out = r_drop_cnt;
`else
  logic w_unused_cfg;

  assign w_timeout      = 1'b0;
  assign drop_count_out = '0;
  assign w_unused_cfg   = (TIMEOUT_CYCLES == 0) | w_done1 | w_done2;
`endif

endmodule

// File: tb/tb_centroid_pair_collector.sv
// Bench for centroid_pair_collector: beat tables with hand-marked emit points, a frame model
// feeding a scoreboard, and hand-checked corner values. Covers the COLLECTOR_TIMEOUT_EN build too.
module tb_centroid_pair_collector;

  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int NP  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    num_players_in = '0;
  logic          cen_valid_in = 1'b0;
  logic          cen_ready_out;
  logic          cen_cam_in = 1'b0;
  logic [1:0]    cen_idx_in = '0;
  logic [XW-1:0] cen_x_in = '0;
  logic [YW-1:0] cen_y_in = '0;
  logic          cen_last_in = 1'b0;
  logic          data_valid_out;
  logic [1:0]    num_players_out;
  logic [XW-1:0] x_out_1 [NP];
  logic [XW-1:0] x_out_2 [NP];
  logic [YW-1:0] y_out_1 [NP];
  logic [YW-1:0] y_out_2 [NP];
  logic          incomplete_out;
  logic [7:0]    drop_count_out;

  always #5 clk = ~clk;

  centroid_pair_collector #(
    .MAX_PLAYERS(NP), .X_W(XW), .Y_W(YW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .num_players_in  (num_players_in),
    .cen_valid_in    (cen_valid_in),
    .cen_ready_out   (cen_ready_out),
    .cen_cam_in      (cen_cam_in),
    .cen_idx_in      (cen_idx_in),
    .cen_x_in        (cen_x_in),
    .cen_y_in        (cen_y_in),
    .cen_last_in     (cen_last_in),
    .data_valid_out  (data_valid_out),
    .num_players_out (num_players_out),
    .x_out_1         (x_out_1),
    .x_out_2         (x_out_2),
    .y_out_1         (y_out_1),
    .y_out_2         (y_out_2),
    .incomplete_out  (incomplete_out),
    .drop_count_out  (drop_count_out)
  );

  typedef struct packed {
    logic          cam;
    logic [1:0]    idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
    logic [1:0]    np;
    logic          emit;
  } vec_t;

  typedef struct packed {
    logic [NP-1:0][XW-1:0] x1;
    logic [NP-1:0][XW-1:0] x2;
    logic [NP-1:0][YW-1:0] y1;
    logic [NP-1:0][YW-1:0] y2;
    logic [1:0]            np;
    logic                  inc;
  } frame_t;

  int     n_vec = 0;
  int     n_err = 0;
  frame_t sb_q [$];
  vec_t   tbl [$];
  frame_t mon_exp, mon_act, rst_act;

  logic [XW-1:0] m_bx [2][NP];
  logic [YW-1:0] m_by [2][NP];
  logic [NP-1:0] m_mask [2];
  logic          m_done [2];
  logic [1:0]    m_np;
  logic          m_busy;
  frame_t        m_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample_actual(output frame_t a);
    for (int i = 0; i < NP; i++) begin
      a.x1[i] = x_out_1[i];
      a.x2[i] = x_out_2[i];
      a.y1[i] = y_out_1[i];
      a.y2[i] = y_out_2[i];
    end
    a.np  = num_players_out;
    a.inc = incomplete_out;
  endtask

  task automatic model_clear();
    m_mask[0] = '0;
    m_mask[1] = '0;
    m_done[0] = 1'b0;
    m_done[1] = 1'b0;
    m_busy    = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_np  = '0;
    m_out = '0;
  endtask

  task automatic model_accept(input vec_t v);
    int   c;
    logic inc;
    c = int'(v.cam);
    if (!m_busy) begin
      m_busy = 1'b1;
      m_np   = v.np;
    end
    if (!m_done[c]) begin
      if (v.idx <= m_np) begin
        m_bx[c][v.idx]   = v.x;
        m_by[c][v.idx]   = v.y;
        m_mask[c][v.idx] = 1'b1;
      end
      if (v.last) m_done[c] = 1'b1;
    end
    if (m_done[0] && m_done[1]) begin
      inc = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (i <= int'(m_np) && (!m_mask[0][i] || !m_mask[1][i])) inc = 1'b1;
        if (m_mask[0][i]) begin
          m_out.x1[i] = m_bx[0][i];
          m_out.y1[i] = m_by[0][i];
        end
        if (m_mask[1][i]) begin
          m_out.x2[i] = m_bx[1][i];
          m_out.y2[i] = m_by[1][i];
        end
      end
      m_out.np  = m_np;
      m_out.inc = inc;
      sb_q.push_back(m_out);
      model_clear();
    end
  endtask

  task automatic add(input int cam, input int idx, input int x, input int last, input int np, input int emit);
    vec_t v;
    v.cam  = cam[0];
    v.idx  = idx[1:0];
    v.x    = XW'(x);
    v.y    = YW'(x * 3 + 1);
    v.last = last[0];
    v.np   = np[1:0];
    v.emit = emit[0];
    tbl.push_back(v);
  endtask

  // Called on a falling edge; the beat is accepted on the following rising edge.
  task automatic send_beat(input vec_t v);
    check("ready_before_beat", 64'(cen_ready_out), 64'd1);
    cen_valid_in   = 1'b1;
    cen_cam_in     = v.cam;
    cen_idx_in     = v.idx;
    cen_x_in       = v.x;
    cen_y_in       = v.y;
    cen_last_in    = v.last;
    num_players_in = v.np;
    model_accept(v);
    @(posedge clk);
    @(negedge clk);
    cen_valid_in = 1'b0;
    cen_last_in  = 1'b0;
    check("pulse_after_beat", 64'(data_valid_out), 64'(v.emit));
    if (v.emit) begin
      check("ready_low_in_emit", 64'(cen_ready_out), 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic run_table();
    for (int k = 0; k < tbl.size(); k++) send_beat(tbl[k]);
    tbl.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid_out) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        sample_actual(mon_act);
        check("frame_x1", 64'(mon_act.x1), 64'(mon_exp.x1));
        check("frame_x2", 64'(mon_act.x2), 64'(mon_exp.x2));
        check("frame_y1", 64'(mon_act.y1), 64'(mon_exp.y1));
        check("frame_y2", 64'(mon_act.y2), 64'(mon_exp.y2));
        check("frame_np", 64'(mon_act.np), 64'(mon_exp.np));
        check("frame_incomplete", 64'(mon_act.inc), 64'(mon_exp.inc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    sample_actual(rst_act);
    check("rst_ready", 64'(cen_ready_out), 64'd0);
    check("rst_pulse", 64'(data_valid_out), 64'd0);
    check("rst_x1", 64'(rst_act.x1), 64'd0);
    check("rst_x2", 64'(rst_act.x2), 64'd0);
    check("rst_y1", 64'(rst_act.y1), 64'd0);
    check("rst_y2", 64'(rst_act.y2), 64'd0);
    check("rst_np_inc", 64'({rst_act.np, rst_act.inc}), 64'd0);
    check("rst_drop", 64'(drop_count_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(cen_ready_out), 64'd1);

    // Full four-player frame, camera 1 then camera 2.
    for (int i = 0; i < 4; i++) add(0, i, 10 + i, (i == 3) ? 1 : 0, 3, 0);
    for (int i = 0; i < 4; i++) add(1, i, 20 + i, (i == 3) ? 1 : 0, 3, (i == 3) ? 1 : 0);
    run_table();
    check("full_np_out", 64'(num_players_out), 64'd3);
    check("full_incomplete", 64'(incomplete_out), 64'd0);
    check("full_x2_3", 64'(x_out_2[3]), 64'd23);

    // Interleaved cameras, camera 1 slot 1 overwritten.
    add(0, 0, 30, 0, 3, 0);  add(1, 0, 40, 0, 3, 0);
    add(0, 1, 100, 0, 3, 0); add(1, 1, 41, 0, 3, 0);
    add(0, 1, 200, 0, 3, 0); add(1, 2, 42, 0, 3, 0);
    add(0, 2, 32, 0, 3, 0);  add(1, 3, 43, 1, 3, 0);
    add(0, 3, 33, 1, 3, 1);
    run_table();
    check("overwrite_x1_1", 64'(x_out_1[1]), 64'd200);

    // Two players: idx 3 beats are out of range and discarded.
    add(0, 3, 555, 0, 1, 0); add(0, 0, 50, 0, 1, 0); add(0, 1, 51, 1, 1, 0);
    add(1, 3, 555, 0, 1, 0); add(1, 0, 60, 0, 1, 0); add(1, 1, 61, 1, 1, 1);
    run_table();
    check("range_x1_3_kept", 64'(x_out_1[3]), 64'd33);
    check("range_x2_3_kept", 64'(x_out_2[3]), 64'd43);
    check("range_np_out", 64'(num_players_out), 64'd1);
    check("range_incomplete", 64'(incomplete_out), 64'd0);

    // Minimum-size camera 1 frame missing slot 1.
    add(0, 0, 70, 1, 1, 0); add(1, 0, 80, 0, 1, 0); add(1, 1, 81, 1, 1, 1);
    run_table();
    check("missing_incomplete", 64'(incomplete_out), 64'd1);
    check("missing_x1_1_kept", 64'(x_out_1[1]), 64'd51);
    check("missing_x1_0", 64'(x_out_1[0]), 64'd70);

`ifdef COLLECTOR_TIMEOUT_EN
    add(0, 0, 90, 0, 1, 0); add(0, 1, 91, 1, 1, 0);
    run_table();
    repeat (TMO + 4) @(negedge clk);
    model_clear();
    check("timeout_drop_count", 64'(drop_count_out), 64'd1);
    check("timeout_ready", 64'(cen_ready_out), 64'd1);
    add(0, 0, 92, 0, 1, 0); add(0, 1, 93, 1, 1, 0);
    add(1, 0, 94, 0, 1, 0); add(1, 1, 95, 1, 1, 1);
    run_table();
    check("after_timeout_x1_0", 64'(x_out_1[0]), 64'd92);
    check("after_timeout_drop", 64'(drop_count_out), 64'd1);
`else
    add(0, 0, 90, 0, 1, 0); add(0, 1, 91, 1, 1, 0);
    run_table();
    repeat (TMO + 4) @(negedge clk);
    check("long_wait_drop_tied", 64'(drop_count_out), 64'd0);
    check("long_wait_ready", 64'(cen_ready_out), 64'd1);
    add(1, 0, 94, 0, 1, 0); add(1, 1, 95, 1, 1, 1);
    run_table();
    check("long_wait_x1_0", 64'(x_out_1[0]), 64'd90);
`endif

    // Reset after two beats of a frame.
    add(0, 0, 777, 0, 3, 0); add(1, 0, 778, 0, 3, 0);
    run_table();
    rst_n = 1'b0;
    model_reset();
    #1;
    sample_actual(rst_act);
    check("midrst_ready", 64'(cen_ready_out), 64'd0);
    check("midrst_x1", 64'(rst_act.x1), 64'd0);
    check("midrst_y2", 64'(rst_act.y2), 64'd0);
    check("midrst_np_inc", 64'({rst_act.np, rst_act.inc}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 64'(cen_ready_out), 64'd1);
    add(0, 1, 101, 1, 1, 0); add(1, 0, 102, 0, 1, 0); add(1, 1, 103, 1, 1, 1);
    run_table();
    check("midrst_stale_x1_0", 64'(x_out_1[0]), 64'd0);
    check("midrst_x1_1", 64'(x_out_1[1]), 64'd101);
    check("midrst_incomplete", 64'(incomplete_out), 64'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
